// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Optional build macro used by the arbiter: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  // Both arbiter counters (starvation and timeout) share this width,
  // so STARVE_MAX and TIMEOUT_CYC are limited to 1..255.
  typedef logic [7:0] cnt_t;

  localparam logic        OWNER_IF     = 1'b0;
  localparam logic        OWNER_D      = 1'b1;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  IF_BE        = 4'hF;

  // Increment that sticks at lim instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch (IF) and data (D) requesters.
// D normally wins; IF is forced once D has won STARVE_MAX times in a row
// while IF was waiting. The starvation count advances on the grant strobe.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_stb,
  output logic grant_if,
  output logic grant_d
);

  localparam cnt_t STARVE_LIM = cnt_t'(STARVE_MAX);

  cnt_t starve_cnt_q;
  cnt_t starve_cnt_d;
  logic force_if_s;

  // Winner selection: D first unless IF has been starved long enough.
  always_comb begin
    force_if_s = if_req && (starve_cnt_q == STARVE_LIM);
    grant_d    = d_req && !force_if_s;
    grant_if   = if_req && !grant_d;
  end

  // Starvation count: grows on D wins over a waiting IF, clears otherwise.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_stb) begin
      if (grant_d && if_req) begin
        starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
      end else begin
        starve_cnt_d = 8'd0;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the
// load/store path. One transaction at a time: IDLE -> REQ -> (WAIT) -> RESP.
// Build macro MEM_ARB_TIMEOUT_EN adds an abort after TIMEOUT_CYC cycles in
// REQ/WAIT that answers the owner with TIMEOUT_DATA and pulses arb_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy,
  output logic        arb_err
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_params
    $error("mem_port_arbiter: STARVE_MAX and TIMEOUT_CYC must be in 1..255");
  end

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic        busy_q, busy_d;
  logic        arb_err_q, arb_err_d;
  logic        grant_if_s, grant_d_s, grant_stb_s;
  logic        tmo_hit_s, tmo_abort_s;

  assign grant_stb_s = (state_q == IDLE) && (grant_if_s || grant_d_s);
  assign if_gnt      = (state_q == IDLE) && grant_if_s;
  assign d_gnt       = (state_q == IDLE) && grant_d_s;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .d_req     (d_req),
    .grant_stb (grant_stb_s),
    .grant_if  (grant_if_s),
    .grant_d   (grant_d_s)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam cnt_t TMO_LAST = cnt_t'(TIMEOUT_CYC - 1);

  cnt_t tmo_cnt_q, tmo_cnt_d;

  // Timeout counter: zero whenever idle, so each REQ entry starts fresh.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit_s = 1'b0;
    case (state_q)
      REQ, WAIT: begin
        tmo_hit_s = (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d = sat_inc(tmo_cnt_q, 8'hFF);
      end
      default: tmo_cnt_d = 8'd0;
    endcase
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Transaction sequencing, request latching and next-cycle output values.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    tmo_abort_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d_s) begin
          owner_d = OWNER_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_be;
          state_d = REQ;
        end else if (grant_if_s) begin
          owner_d = OWNER_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = 32'd0;
          be_d    = IF_BE;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ack && mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else if (mem_ack) begin
          state_d = WAIT;
        end else if (tmo_hit_s) begin
          rdata_d     = TIMEOUT_DATA;
          tmo_abort_s = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else if (tmo_hit_s) begin
          rdata_d     = TIMEOUT_DATA;
          tmo_abort_s = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_req_d   = (state_d == REQ);
    if_rvalid_d = (state_d == RESP) && (owner_d == OWNER_IF);
    d_rvalid_d  = (state_d == RESP) && (owner_d == OWNER_D);
    busy_d      = (state_d != IDLE);
    arb_err_d   = tmo_abort_s;
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      busy_q      <= 1'b0;
      arb_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      busy_q      <= busy_d;
      arb_err_q   <= arb_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign arb_err   = arb_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized request/memory timing, checked against a transaction-level model.
// Timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX  = 4;
  localparam int TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we, mem_ack, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, owner, busy, arb_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: pending requests and the starvation rule.
  bit          pend_if, pend_d;
  logic [31:0] m_if_addr, m_d_addr, m_d_wdata;
  logic        m_d_we;
  logic [3:0]  m_d_be;
  int          starve_m;
  logic        obs_win_d;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic [31:0] a);
    pend_if = 1'b1; m_if_addr = a;
    if_req = 1'b1; if_addr = a;
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    pend_d = 1'b1; m_d_we = we; m_d_addr = a; m_d_wdata = wd; m_d_be = be;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
  endtask

  task automatic check_quiet(input string tag);
    check1({tag, "_if_gnt"}, if_gnt, 1'b0);
    check1({tag, "_d_gnt"}, d_gnt, 1'b0);
    check1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    check1({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    check32({tag, "_if_rdata"}, if_rdata, 32'd0);
    check32({tag, "_d_rdata"}, d_rdata, 32'd0);
    check1({tag, "_mem_req"}, mem_req, 1'b0);
    check1({tag, "_mem_we"}, mem_we, 1'b0);
    check32({tag, "_mem_addr"}, mem_addr, 32'd0);
    check32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check32({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    check1({tag, "_owner"}, owner, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_arb_err"}, arb_err, 1'b0);
  endtask

  task automatic check_req(input logic win_d, input logic e_we, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic [3:0] e_be);
    check1("req_mem_req", mem_req, 1'b1);
    check1("req_mem_we", mem_we, e_we);
    check32("req_mem_addr", mem_addr, e_addr);
    check32("req_mem_be", {28'd0, mem_be}, {28'd0, e_be});
    if (win_d) check32("req_mem_wdata", mem_wdata, e_wdata);
    check1("req_owner", owner, win_d);
    check1("req_busy", busy, 1'b1);
    check1("req_no_gnt", if_gnt | d_gnt, 1'b0);
  endtask

  // One complete transaction starting in IDLE. ack_wait: REQ cycles before
  // mem_ack; lat: cycles from ack to mem_rvalid (0 = same cycle).
  task automatic serve(input int ack_wait, input int lat, input logic [31:0] data);
    logic        win_d, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    win_d = pend_d && !(pend_if && starve_m == STARVE_MAX);
    if (win_d) begin
      e_we = m_d_we; e_addr = m_d_addr; e_wdata = m_d_wdata; e_be = m_d_be;
    end else begin
      e_we = 1'b0; e_addr = m_if_addr; e_wdata = 32'd0; e_be = 4'hF;
    end
    mem_ack = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
    #2;
    check1("idle_busy", busy, 1'b0);
    check1("idle_mem_req", mem_req, 1'b0);
    check1("idle_rvalid", if_rvalid | d_rvalid, 1'b0);
    check1("if_gnt", if_gnt, !win_d);
    check1("d_gnt", d_gnt, win_d);
    obs_win_d = d_gnt;
    if (win_d && pend_if) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
    else starve_m = 0;
    tick();
    if (win_d) begin
      pend_d = 1'b0; d_req = 1'b0; d_addr = $urandom(); d_wdata = $urandom();
      d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
    end else begin
      pend_if = 1'b0; if_req = 1'b0; if_addr = $urandom();
    end
    for (int i = 0; i < ack_wait; i++) begin
      mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
      #2; check_req(win_d, e_we, e_addr, e_wdata, e_be);
      tick();
    end
    mem_ack = 1'b1; mem_rvalid = (lat == 0);
    mem_rdata = (lat == 0) ? data : $urandom();
    #2; check_req(win_d, e_we, e_addr, e_wdata, e_be);
    tick();
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    if (lat > 0) begin
      for (int i = 0; i < lat - 1; i++) begin
        #2;
        check1("wait_mem_req", mem_req, 1'b0);
        check1("wait_busy", busy, 1'b1);
        check1("wait_rvalid", if_rvalid | d_rvalid, 1'b0);
        tick();
      end
      mem_rvalid = 1'b1; mem_rdata = data;
      #2; check1("wait_last_mem_req", mem_req, 1'b0);
      tick();
      mem_rvalid = 1'b0;
    end
    #2;
    check1("resp_if_rvalid", if_rvalid, !win_d);
    check1("resp_d_rvalid", d_rvalid, win_d);
    if (win_d) check32("resp_d_rdata", d_rdata, data);
    else       check32("resp_if_rdata", if_rdata, data);
    check1("resp_mem_req", mem_req, 1'b0);
    check1("resp_arb_err", arb_err, 1'b0);
    check1("resp_owner", owner, win_d);
    tick();
  endtask

  initial begin
    reset_n = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0;
    d_wdata = 32'd0; d_be = 4'd0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    pend_if = 1'b0; pend_d = 1'b0; starve_m = 0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 check_quiet("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // IF-only fetch, zero-wait ack, data one cycle later.
    set_if(32'h0000_0100);
    serve(0, 1, 32'h0000_0013);

    // Simultaneous IF and D store: D first, IF right after.
    set_if(32'h0000_0200);
    set_d(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b0011);
    serve(0, 1, $urandom());
    check1("simul_first_is_d", obs_win_d, 1'b1);
    serve(0, 1, 32'h0BAD_CAFE);
    check1("simul_second_is_if", obs_win_d, 1'b0);

    // Starvation: D always requesting, IF waiting -> four D wins then IF.
    set_if(32'h0000_0600);
    for (int k = 0; k < 5; k++) begin
      if (!pend_d) set_d(1'b0, 32'h0000_1000 + 32'(k * 4), $urandom(), 4'hF);
      serve(0, 0, $urandom());
      check1("starve_grant_order", obs_win_d, (k < 4));
    end
    set_d(1'b0, 32'h0000_2000, 32'd0, 4'hF);
    serve(0, 0, $urandom());

    // mem_ack and mem_rvalid together.
    set_d(1'b0, 32'h0000_0040, 32'd0, 4'hF);
    serve(0, 0, 32'h0000_1234);

    // Reset in WAIT, then a late memory response.
    set_if(32'h0000_0400);
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    #2 check1("rst_if_gnt", if_gnt, 1'b1);
    tick();
    pend_if = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_quiet("rst_mid_wait");
    tick();
    reset_n = 1'b1; starve_m = 0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #2 check_quiet("rst_late_resp");
    tick();
    #2 check_quiet("rst_after");
    tick();
    mem_rvalid = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never acks: abort after TIMEOUT_CYC cycles.
    set_if(32'h0000_0500);
    #2 check1("tmo_if_gnt", if_gnt, 1'b1);
    starve_m = 0;
    tick();
    pend_if = 1'b0; if_req = 1'b0;
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      #2;
      check1("tmo_mem_req", mem_req, 1'b1);
      check1("tmo_arb_err_early", arb_err, 1'b0);
      tick();
    end
    #2;
    check1("tmo_arb_err", arb_err, 1'b1);
    check1("tmo_if_rvalid", if_rvalid, 1'b1);
    check32("tmo_if_rdata", if_rdata, 32'hDEAD_BEEF);
    check1("tmo_mem_req_drop", mem_req, 1'b0);
    check1("tmo_d_rvalid", d_rvalid, 1'b0);
    tick();
    #2;
    check1("tmo_idle_arb_err", arb_err, 1'b0);
    check1("tmo_idle_busy", busy, 1'b0);
    tick();
`endif

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!pend_if && $urandom_range(0, 1) == 1) set_if($urandom() & 32'hFFFF_FFFC);
      if (!pend_d && $urandom_range(0, 2) != 0)
        set_d(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      if (!pend_if && !pend_d) set_if($urandom() & 32'hFFFF_FFFC);
      serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom());
    end
    if (pend_if) serve(0, 0, $urandom());
    if (pend_d)  serve(0, 0, $urandom());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
